bus_req_decoder: RTL and testbench

- Master-side request decoder and sequencer for the three-slave read/write bus.
- Takes one master request (addr, wdata, byte enables, ren/wen) and decodes the address into one of three slave windows.
- Drives the one-hot slave selects (addr_valid1..3) and the shared request lines, then waits for the selected slave to finish.
- Returns the captured read data, or an error for unmapped, illegal or timed-out accesses.
- It is the request/outbound counterpart of the read-data return path.

---
 rtl/bus_req_decoder_pkg.sv | 34 +++
 rtl/bus_req_decoder_if.sv | 50 +++++
 rtl/bus_req_decoder_addr_window_decode.sv | 37 +++
 rtl/bus_req_decoder.sv | 152 +++++++++++++++
 tb/tb_bus_req_decoder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_req_decoder_pkg.sv
// rtl/bus_req_decoder_pkg.sv - shared types and constants for the three-slave request decoder
package bus_req_decoder_pkg;

    // Request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int NUM_SLAVES = 3;

    // Bit positions of each slave inside select / busy vectors
    localparam int SLV1_IDX = 0;
    localparam int SLV2_IDX = 1;
    localparam int SLV3_IDX = 2;

    localparam logic [31:0] DEF_BASE1 = 32'h0000_0000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_BASE2 = 32'h8000_0000;
    localparam logic [31:0] DEF_MASK2 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_BASE3 = 32'h8001_0000;
    localparam logic [31:0] DEF_MASK3 = 32'hFFFF_0000;

    localparam int DEF_TIMEOUT = 64;

    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_req_decoder_if.sv
// rtl/bus_req_decoder_if.sv - master request and slave bus bundle for the request decoder
//   master  : m_ren/m_wen/m_addr/m_wdata/m_byte_en out, m_busy/m_rdata/m_error in
//   slave   : s_* strobes, latched request and addr_valid1..3 in, s_busy/rdata1..3 out
//   decoder : the sequencer's view of both sides
interface bus_req_decoder_if
    import bus_req_decoder_pkg::*;
    ;

    logic                  m_ren;
    logic                  m_wen;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_byte_en;
    logic                  m_busy;
    logic [31:0]           m_rdata;
    logic                  m_error;

    logic                  s_ren;
    logic                  s_wen;
    logic [31:0]           s_addr;
    logic [31:0]           s_wdata;
    logic [3:0]            s_byte_en;
    logic                  addr_valid1;
    logic                  addr_valid2;
    logic                  addr_valid3;
    logic [NUM_SLAVES-1:0] s_busy;
    logic [31:0]           rdata1;
    logic [31:0]           rdata2;
    logic [31:0]           rdata3;

    modport master (
        output m_ren, m_wen, m_addr, m_wdata, m_byte_en,
        input  m_busy, m_rdata, m_error
    );

    modport slave (
        input  s_ren, s_wen, s_addr, s_wdata, s_byte_en,
        input  addr_valid1, addr_valid2, addr_valid3,
        output s_busy, rdata1, rdata2, rdata3
    );

    modport decoder (
        input  m_ren, m_wen, m_addr, m_wdata, m_byte_en,
        output m_busy, m_rdata, m_error,
        output s_ren, s_wen, s_addr, s_wdata, s_byte_en,
        output addr_valid1, addr_valid2, addr_valid3,
        input  s_busy, rdata1, rdata2, rdata3
    );

endinterface

// File: rtl/bus_req_decoder_addr_window_decode.sv
// rtl/bus_req_decoder_addr_window_decode.sv - priority address-window match for three slaves
//   i_addr : address to decode
//   o_hit  : one-hot window hit (slave 1 > slave 2 > slave 3), all-zero when unmapped
module addr_window_decode
    import bus_req_decoder_pkg::*;
#(
    parameter logic [31:0] BASE1 = DEF_BASE1,
    parameter logic [31:0] MASK1 = DEF_MASK1,
    parameter logic [31:0] BASE2 = DEF_BASE2,
    parameter logic [31:0] MASK2 = DEF_MASK2,
    parameter logic [31:0] BASE3 = DEF_BASE3,
    parameter logic [31:0] MASK3 = DEF_MASK3
) (
    input  logic [31:0]           i_addr,
    output logic [NUM_SLAVES-1:0] o_hit
);

    logic [NUM_SLAVES-1:0] w_raw;

    assign w_raw[SLV1_IDX] = win_hit(i_addr, BASE1, MASK1);
    assign w_raw[SLV2_IDX] = win_hit(i_addr, BASE2, MASK2);
    assign w_raw[SLV3_IDX] = win_hit(i_addr, BASE3, MASK3);

    // Overlapping windows resolve to the lowest-numbered slave so the
    // select stays one-hot.
    always_comb begin
        o_hit = '0;
        if (w_raw[SLV1_IDX]) begin
            o_hit[SLV1_IDX] = 1'b1;
        end else if (w_raw[SLV2_IDX]) begin
            o_hit[SLV2_IDX] = 1'b1;
        end else if (w_raw[SLV3_IDX]) begin
            o_hit[SLV3_IDX] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_req_decoder.sv
// rtl/bus_req_decoder.sv - master-side request decoder and sequencer for the three-slave bus
//   CLK  : clock
//   nRST : synchronous active-low reset
//   bus  : decoder modport; master request/response and shared slave lines
module bus_req_decoder
    import bus_req_decoder_pkg::*;
#(
    parameter logic [31:0] BASE1   = DEF_BASE1,
    parameter logic [31:0] MASK1   = DEF_MASK1,
    parameter logic [31:0] BASE2   = DEF_BASE2,
    parameter logic [31:0] MASK2   = DEF_MASK2,
    parameter logic [31:0] BASE3   = DEF_BASE3,
    parameter logic [31:0] MASK3   = DEF_MASK3,
    parameter int          TIMEOUT = DEF_TIMEOUT
) (
    input  logic               CLK,
    input  logic               nRST,
    bus_req_decoder_if.decoder bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_SLAVES-1:0] r_sel;
    logic                  r_op_read;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_byte_en;
    logic [31:0]           r_rdata;
    logic [CNT_W-1:0]      r_cnt;

    logic [NUM_SLAVES-1:0] w_hit;
    logic                  w_req;
    logic                  w_illegal;
    logic                  w_unmapped;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_cnt_inc;
    logic                  w_in_access;
    logic                  w_sel_busy;
    logic [31:0]           w_sel_rdata;

    addr_window_decode #(
        .BASE1 (BASE1),
        .MASK1 (MASK1),
        .BASE2 (BASE2),
        .MASK2 (MASK2),
        .BASE3 (BASE3),
        .MASK3 (MASK3)
    ) u_decode (
        .i_addr (bus.m_addr),
        .o_hit  (w_hit)
    );

    assign w_req      = bus.m_ren | bus.m_wen;
    assign w_illegal  = bus.m_ren & bus.m_wen;
    assign w_unmapped = ~|w_hit;

    // Only the slave picked at accept time is allowed to stall or supply data.
    assign w_sel_busy  = |(bus.s_busy & r_sel);
    assign w_sel_rdata = ({32{r_sel[SLV1_IDX]}} & bus.rdata1)
                       | ({32{r_sel[SLV2_IDX]}} & bus.rdata2)
                       | ({32{r_sel[SLV3_IDX]}} & bus.rdata3);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_illegal || w_unmapped) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_accept    = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!w_sel_busy) begin
                    w_state_nxt = ST_DONE;
                    w_finish    = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_ERR;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and read-data capture
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_sel     <= '0;
            r_op_read <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_byte_en <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_accept) begin
                r_sel     <= w_hit;
                r_op_read <= bus.m_ren;
                r_addr    <= bus.m_addr;
                r_wdata   <= bus.m_wdata;
                r_byte_en <= bus.m_byte_en;
                r_cnt     <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish && r_op_read) begin
                r_rdata <= w_sel_rdata;
            end
        end
    end

    assign w_in_access = (r_state == ST_ACCESS);

    assign bus.addr_valid1 = w_in_access & r_sel[SLV1_IDX];
    assign bus.addr_valid2 = w_in_access & r_sel[SLV2_IDX];
    assign bus.addr_valid3 = w_in_access & r_sel[SLV3_IDX];
    assign bus.s_ren       = w_in_access & r_op_read;
    assign bus.s_wen       = w_in_access & ~r_op_read;
    assign bus.s_addr      = r_addr;
    assign bus.s_wdata     = r_wdata;
    assign bus.s_byte_en   = r_byte_en;

    // Busy drops combinationally in the completion cycle, so it is already
    // high in the request's first IDLE cycle.
    assign bus.m_busy  = w_req & ~((r_state == ST_DONE) | (r_state == ST_ERR));
    assign bus.m_error = (r_state == ST_ERR);
    assign bus.m_rdata = r_rdata;

endmodule

// File: tb/tb_bus_req_decoder.sv
// tb/tb_bus_req_decoder.sv - randomized self-checking bench for bus_req_decoder
module tb_bus_req_decoder;
    import bus_req_decoder_pkg::*;

    localparam int TO = 64;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    bus_req_decoder_if bus ();
    bus_req_decoder_if bus_b ();

    bus_req_decoder #(.TIMEOUT(TO)) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Overlapping windows 1/2 and the smallest timeout
    bus_req_decoder #(
        .BASE2   (32'h0000_0000),
        .MASK2   (32'hFFFF_0000),
        .TIMEOUT (1)
    ) u_dut_b (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window membership with the default map: 1-based slave number, 0 = unmapped
    function automatic int exp_slave(input logic [31:0] a);
        case (a[31:16])
            16'h0000: return 1;
            16'h8000: return 2;
            16'h8001: return 3;
            default:  return 0;
        endcase
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input int busy_n, input logic [31:0] r1, input string tag);
        int          idx, exp_done_n, exp_sel_n, n, sel_n, ren_n, wen_n, bad;
        logic        exp_err, done;
        logic [31:0] rd [3];
        logic [2:0]  onehot, sel, s;

        idx   = exp_slave(addr);
        rd[0] = r1;
        rd[1] = $urandom;
        rd[2] = $urandom;
        if ((ren && wen) || idx == 0) begin
            exp_err = 1'b1; exp_done_n = 1; exp_sel_n = 0;
        end else if (busy_n >= TO) begin
            exp_err = 1'b1; exp_done_n = TO + 1; exp_sel_n = TO;
        end else begin
            exp_err = 1'b0; exp_done_n = busy_n + 2; exp_sel_n = busy_n + 1;
        end
        onehot = (idx == 0) ? 3'b000 : (3'b001 << (idx - 1));

        bus.m_ren     = ren;
        bus.m_wen     = wen;
        bus.m_addr    = addr;
        bus.m_wdata   = wdata;
        bus.m_byte_en = be;
        bus.rdata1    = rd[0];
        bus.rdata2    = rd[1];
        bus.rdata3    = rd[2];
        bus.s_busy    = 3'($urandom);
        #1;
        check_eq({tag, "_busy_first"}, 32'(bus.m_busy), 32'd1);

        done = 1'b0; n = 0; sel_n = 0; ren_n = 0; wen_n = 0; bad = 0;
        while (!done && n < TO + 8) begin
            @(negedge CLK);
            n++;
            sel = {bus.addr_valid3, bus.addr_valid2, bus.addr_valid1};
            if (bus.m_busy == 1'b0) done = 1'b1;
            else if (bus.m_error) bad++;
            if (sel != 3'b000) begin
                sel_n++;
                if (sel != onehot) bad++;
                if (bus.s_addr != addr || bus.s_wdata != wdata || bus.s_byte_en != be) bad++;
            end
            if (bus.s_ren) ren_n++;
            if (bus.s_wen) wen_n++;
            if (!done) begin
                // ACCESS cycle n-1 is being evaluated at the coming edge
                s = 3'($urandom);
                if (idx != 0) s[idx-1] = ((n - 1) < busy_n);
                bus.s_busy    = s;
                bus.m_addr    = $urandom;
                bus.m_wdata   = $urandom;
                bus.m_byte_en = 4'($urandom);
            end
        end

        check_eq({tag, "_completed"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, 32'(n), 32'(exp_done_n));
        check_eq({tag, "_error"}, 32'(bus.m_error), 32'(exp_err));
        check_eq({tag, "_sel_cycles"}, 32'(sel_n), 32'(exp_sel_n));
        check_eq({tag, "_ren_cycles"}, 32'(ren_n), ren ? 32'(exp_sel_n) : 32'd0);
        check_eq({tag, "_wen_cycles"}, 32'(wen_n), wen ? 32'(exp_sel_n) : 32'd0);
        check_eq({tag, "_cycle_faults"}, 32'(bad), 32'd0);
        if (!exp_err && ren) last_rdata = rd[idx-1];
        check_eq({tag, "_rdata"}, bus.m_rdata, last_rdata);

        bus.m_ren = 1'b0;
        bus.m_wen = 1'b0;
        @(negedge CLK);
    endtask

    logic [15:0] unmapped_hi [4] = '{16'h4000, 16'h8002, 16'hFFFF, 16'h0001};

    initial begin
        int          w, r, busy;
        logic [31:0] a;
        logic        ren, wen;
        int          err_pulses, sel_pulses;

        bus.m_ren = 0; bus.m_wen = 0; bus.m_addr = 0; bus.m_wdata = 0; bus.m_byte_en = 0;
        bus.s_busy = 0; bus.rdata1 = 0; bus.rdata2 = 0; bus.rdata3 = 0;
        bus_b.m_ren = 0; bus_b.m_wen = 0; bus_b.m_addr = 0; bus_b.m_wdata = 0; bus_b.m_byte_en = 0;
        bus_b.s_busy = 0; bus_b.rdata1 = 0; bus_b.rdata2 = 0; bus_b.rdata3 = 0;

        repeat (3) @(negedge CLK);
        check_eq("rst_sel", 32'({bus.addr_valid3, bus.addr_valid2, bus.addr_valid1}), 32'd0);
        check_eq("rst_strobes", 32'({bus.s_ren, bus.s_wen}), 32'd0);
        check_eq("rst_saddr", bus.s_addr, 32'd0);
        check_eq("rst_rdata", bus.m_rdata, 32'd0);
        check_eq("rst_error", 32'(bus.m_error), 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, "rd1_zero_wait");
        run_txn(1'b0, 1'b1, 32'h8001_0004, 32'h1234_5678, 4'b0011, 5, $urandom, "wr3_wait5");
        run_txn(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, $urandom, "unmapped");
        run_txn(1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF, TO + 10, $urandom, "rd2_timeout");
        run_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'hF, TO - 1, $urandom, "rd2_last_wait");
        run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h5, 4'hF, 0, $urandom, "illegal_op");

        for (int t = 0; t < 40; t++) begin
            w = $urandom_range(0, 3);
            case (w)
                0:       a = {16'h0000, 16'($urandom)};
                1:       a = {16'h8000, 16'($urandom)};
                2:       a = {16'h8001, 16'($urandom)};
                default: a = {unmapped_hi[$urandom_range(0, 3)], 16'($urandom)};
            endcase
            r = $urandom_range(0, 9);
            ren = (r == 0) || (r < 5);
            wen = (r == 0) || (r >= 5);
            r = $urandom_range(0, 19);
            busy = (r == 0) ? TO - 1 : (r == 1) ? TO + 3 : $urandom_range(0, 6);
            run_txn(ren, wen, a, $urandom, 4'($urandom), busy, $urandom, "rand");
        end

        // Make sure m_rdata holds something nonzero before the reset check
        run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'hCAFE_F00D, "rd1_pre_reset");

        // Reset while slave 2 stalls
        bus.m_ren  = 1'b1;
        bus.m_addr = 32'h8000_0008;
        bus.s_busy = 3'b010;
        repeat (3) @(negedge CLK);
        check_eq("mid_sel_before_reset", 32'(bus.addr_valid2), 32'd1);
        nRST = 1'b0;
        bus.m_ren = 1'b0;
        @(negedge CLK);
        check_eq("mid_rst_sel", 32'({bus.addr_valid3, bus.addr_valid2, bus.addr_valid1}), 32'd0);
        check_eq("mid_rst_strobes", 32'({bus.s_ren, bus.s_wen}), 32'd0);
        check_eq("mid_rst_saddr", bus.s_addr, 32'd0);
        check_eq("mid_rst_swdata", bus.s_wdata, 32'd0);
        check_eq("mid_rst_sbe", 32'(bus.s_byte_en), 32'd0);
        check_eq("mid_rst_rdata", bus.m_rdata, 32'd0);
        check_eq("mid_rst_err_busy", 32'({bus.m_error, bus.m_busy}), 32'd0);
        last_rdata = '0;
        err_pulses = 0;
        sel_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) nRST = 1'b1;
            @(negedge CLK);
            if (bus.m_error) err_pulses++;
            if (bus.addr_valid1 || bus.addr_valid2 || bus.addr_valid3) sel_pulses++;
        end
        check_eq("mid_rst_no_err_pulse", 32'(err_pulses), 32'd0);
        check_eq("mid_rst_no_sel", 32'(sel_pulses), 32'd0);
        run_txn(1'b1, 1'b0, 32'h8001_0000, 32'h0, 4'hF, 2, $urandom, "after_reset");

        // Overlap: window 2 duplicates window 1, slave 1 must win
        bus_b.m_ren  = 1'b1;
        bus_b.m_addr = 32'h0000_0020;
        bus_b.s_busy = 3'b000;
        bus_b.rdata1 = 32'hA5A5_0001;
        bus_b.rdata2 = 32'h5A5A_0002;
        @(negedge CLK);
        check_eq("ovl_sel", 32'({bus_b.addr_valid3, bus_b.addr_valid2, bus_b.addr_valid1}), 32'b001);
        @(negedge CLK);
        check_eq("ovl_done", 32'({bus_b.m_busy, bus_b.m_error}), 32'd0);
        check_eq("ovl_rdata", bus_b.m_rdata, 32'hA5A5_0001);
        bus_b.m_ren = 1'b0;
        @(negedge CLK);

        // TIMEOUT=1: a single busy cycle errors
        bus_b.m_ren  = 1'b1;
        bus_b.m_addr = 32'h0000_0030;
        bus_b.s_busy = 3'b001;
        @(negedge CLK);
        check_eq("to1_sel", 32'({bus_b.addr_valid3, bus_b.addr_valid2, bus_b.addr_valid1}), 32'b001);
        @(negedge CLK);
        check_eq("to1_err", 32'({bus_b.m_busy, bus_b.m_error}), 32'b01);
        check_eq("to1_sel_drop", 32'({bus_b.addr_valid3, bus_b.addr_valid2, bus_b.addr_valid1}), 32'd0);
        bus_b.m_ren = 1'b0;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
